dff_pipe_chain: RTL and testbench

- Parametrised successor to the single-bit D flip-flop.
- A WIDTH-bit by DEPTH-stage register chain with per-stage valid bits and a valid/ready handshake.
- Stalls collapse bubbles: an empty stage accepts data even while the output is blocked.
- Used as a retiming/delay element between datapath blocks, with a synchronous flush for pipeline recovery.

---
 rtl/dff_pipe_pkg.sv | 22 ++
 rtl/dff_pipe_stage.sv | 60 ++++++
 rtl/dff_pipe_chain.sv | 125 ++++++++++++
 tb/tb_dff_pipe_chain.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dff_pipe_pkg.sv
// -----------------------------------------------------------------------------
// dff_pipe_pkg
// Shared definitions for the dff_pipe_chain register chain:
//   - MIN_WIDTH / MIN_DEPTH : smallest legal values of the chain parameters
//   - clog2_p1(n)           : bits needed to hold any value 0..n (at least 1)
// -----------------------------------------------------------------------------
package dff_pipe_pkg;

    localparam int MIN_WIDTH = 1;
    localparam int MIN_DEPTH = 1;

    // Width of a counter that must represent 0..n inclusive.
    function automatic int clog2_p1(input int n);
        int w;
        w = 0;
        while ((64'd1 << w) < 64'(n + 1)) begin
            w = w + 1;
        end
        return (w < 1) ? 1 : w;
    endfunction

endpackage : dff_pipe_pkg

// File: rtl/dff_pipe_stage.sv
// -----------------------------------------------------------------------------
// dff_pipe_stage
// One register stage of dff_pipe_chain: a data register, its valid bit, and
// the stage's ready term (empty, or the stage downstream can move).
//
// Ports:
//   clk         in   rising-edge clock
//   reset       in   synchronous active-high reset
//   flush       in   synchronous clear of the valid bit (data holds)
//   i_up_valid  in   upstream stage / input transfer carries a word
//   i_up_data   in   upstream word
//   i_dn_rdy    in   ready of the next stage (out_ready for the last stage)
//   o_vld       out  registered valid bit
//   o_data      out  registered data word
//   o_rdy       out  this stage can take a new word this cycle
// -----------------------------------------------------------------------------
module dff_pipe_stage #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             i_up_valid,
    input  logic [WIDTH-1:0] i_up_data,
    input  logic             i_dn_rdy,
    output logic             o_vld,
    output logic [WIDTH-1:0] o_data,
    output logic             o_rdy
);

    logic             r_vld;
    logic [WIDTH-1:0] r_data;

    // An empty stage always accepts, which is what collapses bubbles.
    assign o_rdy = ~r_vld | i_dn_rdy;

    // NOTE: state registers use non-blocking assignments so every stage samples
    // its neighbour's pre-edge value; blocking here would let words race ahead.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_vld  <= 1'b0;
            // NOTE: the data registers are reset too (not only the valid bit) so
            // out_data shows a defined RESET_VAL while the chain is empty.
            r_data <= RESET_VAL;
        end else if (flush) begin
            r_vld  <= 1'b0;
        end else if (o_rdy) begin
            r_vld <= i_up_valid;
            // Load only real words; bubbles leave the data register untouched.
            if (i_up_valid) begin
                r_data <= i_up_data;
            end
        end
    end

    assign o_vld  = r_vld;
    assign o_data = r_data;

endmodule : dff_pipe_stage

// File: rtl/dff_pipe_chain.sv
// -----------------------------------------------------------------------------
// dff_pipe_chain
// WIDTH-bit x DEPTH-stage register chain with per-stage valid bits and a
// valid/ready handshake on both ends. Empty stages accept data even while the
// output is blocked, so bubbles collapse under backpressure. A synchronous
// flush clears every valid bit; data registers hold.
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   synchronous active-high reset (priority over flush)
//   flush      in   synchronous clear of all valid bits; blocks input
//   in_valid   in   upstream offers in_data
//   in_ready   out  chain accepts in_data this cycle
//   in_data    in   input word [WIDTH]
//   out_valid  out  last stage holds a valid word
//   out_ready  in   downstream accepts out_data this cycle
//   out_data   out  last-stage word [WIDTH]
//   occupancy  out  number of valid stages (only with DFF_PIPE_OCCUPANCY_EN)
//
// Optional build macro: DFF_PIPE_OCCUPANCY_EN adds the occupancy counter/port
// and a simulation check that it matches the number of set valid bits.
// -----------------------------------------------------------------------------
module dff_pipe_chain
    import dff_pipe_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter int               DEPTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
`ifdef DFF_PIPE_OCCUPANCY_EN
    ,
    output logic [clog2_p1(DEPTH)-1:0] occupancy
`endif
);

    if (WIDTH < MIN_WIDTH || DEPTH < MIN_DEPTH) begin : g_bad_param
        $error("dff_pipe_chain: WIDTH (%0d) and DEPTH (%0d) must both be >= 1",
               WIDTH, DEPTH);
    end

    logic [DEPTH-1:0] w_vld;
    logic [WIDTH-1:0] w_data [DEPTH];
    logic             w_in_xfer;

    // Stage 0's ready is the OR of "any stage empty" and out_ready, rippled
    // combinationally from the last stage; flush blocks new words outright.
    assign in_ready  = g_stage[0].w_rdy & ~flush;
    assign w_in_xfer = in_valid & in_ready;

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic             w_rdy;
        logic             w_dn_rdy;
        logic             w_up_valid;
        logic [WIDTH-1:0] w_up_data;

        if (i == 0) begin : g_head
            assign w_up_valid = w_in_xfer;
            assign w_up_data  = in_data;
        end else begin : g_body
            assign w_up_valid = w_vld[i-1];
            assign w_up_data  = w_data[i-1];
        end

        if (i == DEPTH - 1) begin : g_tail
            assign w_dn_rdy = out_ready;
        end else begin : g_link
            assign w_dn_rdy = g_stage[i+1].w_rdy;
        end

        dff_pipe_stage #(
            .WIDTH     (WIDTH),
            .RESET_VAL (RESET_VAL)
        ) u_stage (
            .clk        (clk),
            .reset      (reset),
            .flush      (flush),
            .i_up_valid (w_up_valid),
            .i_up_data  (w_up_data),
            .i_dn_rdy   (w_dn_rdy),
            .o_vld      (w_vld[i]),
            .o_data     (w_data[i]),
            .o_rdy      (w_rdy)
        );
    end

    assign out_valid = w_vld[DEPTH-1];
    assign out_data  = w_data[DEPTH-1];

`ifdef DFF_PIPE_OCCUPANCY_EN
    localparam int OCC_W = clog2_p1(DEPTH);

    logic [OCC_W-1:0] r_occupancy;
    logic             w_out_xfer;

    assign w_out_xfer = out_valid & out_ready;

    // Simultaneous accept and emit leaves the count unchanged.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_occupancy <= '0;
        end else if (w_in_xfer && !w_out_xfer) begin
            r_occupancy <= r_occupancy + OCC_W'(1);
        end else if (!w_in_xfer && w_out_xfer) begin
            r_occupancy <= r_occupancy - OCC_W'(1);
        end
    end

    assign occupancy = r_occupancy;

    a_occ_popcount : assert property (
        @(posedge clk) disable iff (reset)
        int'(r_occupancy) == $countones(w_vld)
    );
`endif

endmodule : dff_pipe_chain

// File: tb/tb_dff_pipe_chain.sv
// -----------------------------------------------------------------------------
// tb_dff_pipe_chain
// Self-checking bench for dff_pipe_chain. A DEPTH=4 instance is compared every
// cycle against a slot/queue reference model; a DEPTH=1 instance covers the
// degenerate single-stage case. Directed sequences add constant expectations
// for reset, latency, backpressure, flush and mid-stream reset.
// -----------------------------------------------------------------------------
module tb_dff_pipe_chain;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam logic [7:0] RST4 = 8'h00;
    localparam logic [7:0] RST1 = 8'h5A;

    logic       clk;
    logic       reset, flush, in_valid, out_ready;
    logic [7:0] in_data;
    logic       in_ready, out_valid;
    logic [7:0] out_data;

    logic       d1_flush, d1_in_valid, d1_out_ready;
    logic [7:0] d1_in_data;
    logic       d1_in_ready, d1_out_valid;
    logic [7:0] d1_out_data;

`ifdef DFF_PIPE_OCCUPANCY_EN
    logic [dff_pipe_pkg::clog2_p1(DEPTH)-1:0] occupancy;
    logic [dff_pipe_pkg::clog2_p1(1)-1:0]     d1_occupancy;
`endif

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    bit chk_en   = 0;
    bit ir_seen;

    dff_pipe_chain #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RESET_VAL(RST4)) u_dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
`ifdef DFF_PIPE_OCCUPANCY_EN
        ,
        .occupancy (occupancy)
`endif
    );

    dff_pipe_chain #(.WIDTH(WIDTH), .DEPTH(1), .RESET_VAL(RST1)) u_dut_d1 (
        .clk       (clk),
        .reset     (reset),
        .flush     (d1_flush),
        .in_valid  (d1_in_valid),
        .in_ready  (d1_in_ready),
        .in_data   (d1_in_data),
        .out_valid (d1_out_valid),
        .out_ready (d1_out_ready),
        .out_data  (d1_out_data)
`ifdef DFF_PIPE_OCCUPANCY_EN
        ,
        .occupancy (d1_occupancy)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------------------------------------------------------------
    // Reference model: words in acceptance order with their slot position.
    // A word moves up one slot if some slot ahead of it is empty or the
    // consumer takes the head word; the head word leaves on out_ready.
    // ---------------------------------------------------------------------
    typedef struct {
        logic [7:0] data;
        int         pos;
    } word_t;

    word_t      mq[$];
    word_t      nq[$];
    word_t      m_w;
    logic [7:0] m_last = RST4;
    bit         m_acc;

    always @(posedge clk) begin
        if (reset) begin
            mq.delete();
            m_last = RST4;
        end else if (flush) begin
            mq.delete();
        end else begin
            m_acc = in_valid && ((mq.size() < DEPTH) || out_ready);
            nq.delete();
            foreach (mq[k]) begin
                m_w = mq[k];
                if (m_w.pos == DEPTH - 1) begin
                    if (!out_ready) nq.push_back(m_w);
                end else begin
                    // k older words sit in the DEPTH-1-pos slots ahead.
                    if (out_ready || (k < DEPTH - 1 - m_w.pos)) begin
                        m_w.pos = m_w.pos + 1;
                        if (m_w.pos == DEPTH - 1) m_last = m_w.data;
                    end
                    nq.push_back(m_w);
                end
            end
            if (m_acc) begin
                m_w.data = in_data;
                m_w.pos  = 0;
                nq.push_back(m_w);
            end
            mq = nq;
        end
    end

    function automatic logic m_out_valid();
        if (mq.size() == 0) return 1'b0;
        return mq[0].pos == DEPTH - 1;
    endfunction

    function automatic logic m_in_ready();
        return ((mq.size() < DEPTH) || out_ready) && !flush;
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_in_ready",  32'(in_ready),  32'(m_in_ready()));
            check("model_out_valid", 32'(out_valid), 32'(m_out_valid()));
            check("model_out_data",  32'(out_data),  32'(m_last));
`ifdef DFF_PIPE_OCCUPANCY_EN
            check("model_occupancy", 32'(occupancy), 32'(mq.size()));
`endif
        end
    end

    task automatic drv(input logic iv, input logic [7:0] d, input logic ordy,
                       input logic fl, input logic rs);
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        reset     = rs;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Backpressure / bubble-collapse / full-with-transfer vectors.
    typedef struct {
        logic       iv;
        logic [7:0] d;
        logic       ordy;
        logic       e_ir;
        logic       e_ov;
        logic       od_chk;
        logic [7:0] e_od;
    } vec_t;

    function automatic vec_t mk(input logic iv, input logic [7:0] d, input logic ordy,
                                input logic e_ir, input logic e_ov, input logic od_chk,
                                input logic [7:0] e_od);
        vec_t v;
        v.iv = iv; v.d = d; v.ordy = ordy;
        v.e_ir = e_ir; v.e_ov = e_ov; v.od_chk = od_chk; v.e_od = e_od;
        return v;
    endfunction

    vec_t tbl [17];

    initial begin
        tbl[0]  = mk(1, 8'h10, 0, 1, 0, 0, 8'h00);
        tbl[1]  = mk(0, 8'h00, 0, 1, 0, 0, 8'h00);
        tbl[2]  = mk(1, 8'h11, 0, 1, 0, 0, 8'h00);
        tbl[3]  = mk(0, 8'h00, 0, 1, 0, 0, 8'h00);
        tbl[4]  = mk(0, 8'h00, 0, 1, 1, 1, 8'h10);
        tbl[5]  = mk(1, 8'h12, 0, 1, 1, 1, 8'h10);
        tbl[6]  = mk(1, 8'h13, 0, 1, 1, 1, 8'h10);
        tbl[7]  = mk(1, 8'h14, 0, 0, 1, 1, 8'h10);
        tbl[8]  = mk(1, 8'h14, 0, 0, 1, 1, 8'h10);
        tbl[9]  = mk(1, 8'h14, 1, 1, 1, 1, 8'h10);
        tbl[10] = mk(1, 8'h15, 1, 1, 1, 1, 8'h11);
        tbl[11] = mk(1, 8'h16, 1, 1, 1, 1, 8'h12);
        tbl[12] = mk(0, 8'h00, 1, 1, 1, 1, 8'h13);
        tbl[13] = mk(0, 8'h00, 1, 1, 1, 1, 8'h14);
        tbl[14] = mk(0, 8'h00, 1, 1, 1, 1, 8'h15);
        tbl[15] = mk(0, 8'h00, 1, 1, 1, 1, 8'h16);
        tbl[16] = mk(0, 8'h00, 1, 1, 0, 1, 8'h16);

        d1_flush = 1'b0; d1_in_valid = 1'b0; d1_in_data = 8'h00; d1_out_ready = 1'b0;

        // ---- Reset: two cycles with a word offered --------------------------
        drv(1, 8'hAA, 0, 0, 1);
        next_cycle();
        chk_en = 1;
        next_cycle();
        drv(0, 8'h00, 0, 0, 0);
        @(negedge clk);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_out_data",  32'(out_data),  32'(RST4));
        check("reset_in_ready",  32'(in_ready),  32'd1);
        check("d1_reset_data",   32'(d1_out_data), 32'(RST1));
        check("d1_reset_valid",  32'(d1_out_valid), 32'd0);
        for (int c = 0; c < 5; c++) begin
            next_cycle();
            @(negedge clk);
            check("reset_no_word", 32'(out_valid), 32'd0);
        end
        next_cycle();

        // ---- Latency and throughput: push 01..08 with out_ready high --------
        for (int c = 0; c < 16; c++) begin
            if (c < 8) drv(1, 8'(c + 1), 1, 0, 0);
            else       drv(0, 8'h00, 1, 0, 0);
            @(negedge clk);
            if (c < 8) check("lat_in_ready", 32'(in_ready), 32'd1);
            check("lat_out_valid", 32'(out_valid), 32'((c >= 4) && (c < 12)));
            if ((c >= 4) && (c < 12)) check("lat_out_data", 32'(out_data), 32'(c - 3));
            next_cycle();
        end

        // ---- Backpressure, bubble collapse, full with simultaneous transfer -
        foreach (tbl[r]) begin
            drv(tbl[r].iv, tbl[r].d, tbl[r].ordy, 0, 0);
            @(negedge clk);
            check("bp_in_ready",  32'(in_ready),  32'(tbl[r].e_ir));
            check("bp_out_valid", 32'(out_valid), 32'(tbl[r].e_ov));
            if (tbl[r].od_chk) check("bp_out_data", 32'(out_data), 32'(tbl[r].e_od));
            next_cycle();
        end

        // ---- Flush with three words in flight -------------------------------
        for (int c = 0; c < 11; c++) begin
            case (c)
                0, 1, 2: drv(1, 8'(8'h20 + c), 1, 0, 0);
                3:       drv(1, 8'h23, 1, 1, 0);
                5:       drv(1, 8'h30, 1, 0, 0);
                default: drv(0, 8'h00, 1, 0, 0);
            endcase
            @(negedge clk);
            if (c == 3) check("flush_in_ready", 32'(in_ready), 32'd0);
            if (c == 5) check("flush_next_accept", 32'(in_ready), 32'd1);
            check("flush_out_valid", 32'(out_valid), 32'(c == 9));
            if (c == 9) check("flush_out_data", 32'(out_data), 32'h30);
            next_cycle();
        end

        // ---- Reset with the chain full --------------------------------------
        for (int c = 0; c < 7; c++) begin
            if (c < 4)       drv(1, 8'(8'h40 + c), 0, 0, 0);
            else if (c == 5) drv(0, 8'h00, 0, 0, 1);
            else             drv(0, 8'h00, 0, 0, 0);
            @(negedge clk);
            if (c < 4) check("mrst_fill_ready", 32'(in_ready), 32'd1);
            if (c == 4) begin
                check("mrst_full_ready", 32'(in_ready),  32'd0);
                check("mrst_full_data",  32'(out_data),  32'h40);
            end
            if (c == 6) begin
                check("mrst_empty_valid", 32'(out_valid), 32'd0);
                check("mrst_empty_ready", 32'(in_ready),  32'd1);
                check("mrst_empty_data",  32'(out_data),  32'(RST4));
            end
            next_cycle();
        end

        // ---- DEPTH=1 instance: one new word per out_ready pulse -------------
        for (int c = 0; c < 7; c++) begin
            d1_in_valid  = (c < 5);
            d1_in_data   = (c == 0) ? 8'h50 : (c < 3) ? 8'h51 : 8'h52;
            d1_out_ready = (c == 2) || (c == 5);
            @(negedge clk);
            check("d1_in_ready",  32'(d1_in_ready),  32'((c == 0) || (c == 2) || (c >= 5)));
            check("d1_out_valid", 32'(d1_out_valid), 32'((c >= 1) && (c <= 5)));
            if (c == 1 || c == 2)      check("d1_out_data", 32'(d1_out_data), 32'h50);
            if (c >= 3 && c <= 5)      check("d1_out_data", 32'(d1_out_data), 32'h51);
            next_cycle();
        end
        d1_in_valid = 1'b0;

        // ---- Randomised traffic against the model ---------------------------
        ir_seen = 1'b1;
        for (int n = 0; n < 800; n++) begin
            if (!(in_valid && !ir_seen)) begin
                in_valid = ($urandom_range(0, 99) < 60);
                in_data  = 8'($urandom);
            end
            out_ready = ($urandom_range(0, 99) < 70);
            flush     = ($urandom_range(0, 99) < 3);
            reset     = ($urandom_range(0, 199) < 1);
            @(negedge clk);
            ir_seen = in_ready;
            next_cycle();
        end

        drv(0, 8'h00, 1, 0, 0);
        for (int c = 0; c < 8; c++) next_cycle();
        chk_en = 0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_dff_pipe_chain
